// File: rtl/top_dp_pkg.sv
// Shared constants for the top_dp arithmetic datapath: width, calculator
// opcodes and output-mux select encodings.
package top_dp_pkg;

  localparam int W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } calc_op_e;

  typedef enum logic [1:0] {
    SEL_L_ZERO = 2'b00,
    SEL_L_CALC = 2'b01,
    SEL_L_MULT = 2'b10,
    SEL_L_DIV  = 2'b11
  } sel_l_e;

  localparam logic SEL_H_MULT = 1'b0;
  localparam logic SEL_H_DIV  = 1'b1;

endpackage

// File: rtl/top_dp_calc_unit.sv
// Calculator unit: opcode ALU over the shared operands, a result register
// and a sticky done flag.
module dp_calc_unit #(
  parameter int W = top_dp_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         done
);
  import top_dp_pkg::*;

  logic [W-1:0] alu;

  // Add and subtract wrap at W bits; the carry/borrow is intentionally dropped.
  always_comb begin
    alu = '0;
    unique case (calc_op_e'(op))
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_XOR:  alu = a ^ b;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      done   <= 1'b0;
    end else if (go) begin
      result <= alu;
      done   <= 1'b1;
    end
  end

endmodule

// File: rtl/top_dp.sv
// 4-bit datapath: operand registers, calculator/divider/multiplier units and
// two registered output nibbles steered by external-FSM mux selects.
module top_dp #(
  parameter int W = top_dp_pkg::W
) (
  input  logic         en_x,
  input  logic         en_y,
  input  logic         go_calc,
  input  logic         go_div,
  input  logic         go_mult,
  input  logic         sel_h,
  input  logic         en_out_h,
  input  logic         en_out_l,
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   sel_l,
  input  logic [1:0]   op_calc,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         done_calc,
  output logic         done_div,
  output logic         done_mult,
  output logic [W-1:0] out_h,
  output logic [W-1:0] out_l
);
  import top_dp_pkg::*;

  logic [W-1:0]   reg_x, reg_y;
  logic [W-1:0]   calc_result;
  logic [W-1:0]   quotient, remainder;
  logic [2*W-1:0] product;
  logic [W-1:0]   mux_l, mux_h;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_x <= '0;
      reg_y <= '0;
    end else begin
      if (en_x) reg_x <= x;
      if (en_y) reg_y <= y;
    end
  end

  dp_calc_unit #(.W(W)) u_calc (
    .clk    (clk),
    .rst    (rst),
    .go     (go_calc),
    .op     (op_calc),
    .a      (reg_x),
    .b      (reg_y),
    .result (calc_result),
    .done   (done_calc)
  );

  // Division by zero saturates the quotient and passes X through as remainder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      done_div  <= 1'b0;
    end else if (go_div) begin
      if (reg_y == '0) begin
        quotient  <= '1;
        remainder <= reg_x;
      end else begin
        quotient  <= reg_x / reg_y;
        remainder <= reg_x % reg_y;
      end
      done_div <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product   <= '0;
      done_mult <= 1'b0;
    end else if (go_mult) begin
      product   <= {{W{1'b0}}, reg_x} * {{W{1'b0}}, reg_y};
      done_mult <= 1'b1;
    end
  end

  always_comb begin
    mux_l = '0;
    unique case (sel_l_e'(sel_l))
      SEL_L_ZERO: mux_l = '0;
      SEL_L_CALC: mux_l = calc_result;
      SEL_L_MULT: mux_l = product[W-1:0];
      SEL_L_DIV:  mux_l = quotient;
      default:    mux_l = '0;
    endcase
    mux_h = (sel_h == SEL_H_DIV) ? remainder : product[2*W-1:W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_h <= '0;
      out_l <= '0;
    end else begin
      if (en_out_h) out_h <= mux_h;
      if (en_out_l) out_l <= mux_l;
    end
  end

endmodule

// File: tb/tb_top_dp.sv
// Self-checking bench for top_dp: an arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_top_dp;

  logic       clk, rst;
  logic       en_x, en_y, go_calc, go_div, go_mult, sel_h, en_out_h, en_out_l;
  logic [1:0] sel_l, op_calc;
  logic [3:0] x, y;
  logic       done_calc, done_div, done_mult;
  logic [3:0] out_h, out_l;

  int assertions = 0;
  int failures   = 0;

  top_dp dut (
    .en_x(en_x), .en_y(en_y), .go_calc(go_calc), .go_div(go_div),
    .go_mult(go_mult), .sel_h(sel_h), .en_out_h(en_out_h), .en_out_l(en_out_l),
    .clk(clk), .rst(rst), .sel_l(sel_l), .op_calc(op_calc), .x(x), .y(y),
    .done_calc(done_calc), .done_div(done_div), .done_mult(done_mult),
    .out_h(out_h), .out_l(out_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain integer arithmetic on the architectural state.
  int  m_x, m_y, m_calc, m_q, m_r, m_p, m_h, m_l;
  bit  m_dc, m_dd, m_dm;

  always @(posedge clk or posedge rst) begin
    int nh, nl;
    if (rst) begin
      m_x = 0; m_y = 0; m_calc = 0; m_q = 0; m_r = 0; m_p = 0;
      m_h = 0; m_l = 0; m_dc = 0; m_dd = 0; m_dm = 0;
    end else begin
      nh = m_h;
      nl = m_l;
      if (en_out_l) begin
        case (sel_l)
          2'd0: nl = 0;
          2'd1: nl = m_calc;
          2'd2: nl = m_p % 16;
          default: nl = m_q;
        endcase
      end
      if (en_out_h) nh = sel_h ? m_r : m_p / 16;
      if (go_calc) begin
        case (op_calc)
          2'd0: m_calc = (m_x + m_y) % 16;
          2'd1: m_calc = (m_x - m_y + 16) % 16;
          2'd2: m_calc = m_x & m_y;
          default: m_calc = m_x ^ m_y;
        endcase
        m_dc = 1;
      end
      if (go_div) begin
        if (m_y == 0) begin
          m_q = 15;
          m_r = m_x;
        end else begin
          m_q = m_x / m_y;
          m_r = m_x % m_y;
        end
        m_dd = 1;
      end
      if (go_mult) begin
        m_p = m_x * m_y;
        m_dm = 1;
      end
      if (en_x) m_x = int'(x);
      if (en_y) m_y = int'(y);
      m_h = nh;
      m_l = nl;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      assertions++;
      if (int'(out_h) != m_h || int'(out_l) != m_l ||
          done_calc != m_dc || done_div != m_dd || done_mult != m_dm) begin
        failures++;
        $display("[TB] FAIL model_cmp t=%0t: got h=%h l=%h done=%b%b%b, expected h=%h l=%h done=%b%b%b",
                 $time, out_h, out_l, done_calc, done_div, done_mult,
                 m_h, m_l, m_dc, m_dd, m_dm);
      end
    end
  end

  task automatic applyStimulus(input bit lx, input bit ly, input logic [3:0] vx,
                               input logic [3:0] vy, input bit gc, input logic [1:0] op,
                               input bit gd, input bit gm, input bit sh,
                               input logic [1:0] sl, input bit eh, input bit el);
    en_x = lx; en_y = ly; x = vx; y = vy;
    go_calc = gc; op_calc = op; go_div = gd; go_mult = gm;
    sel_h = sh; sel_l = sl; en_out_h = eh; en_out_l = el;
    @(posedge clk);
    #1;
    en_x = 0; en_y = 0; go_calc = 0; go_div = 0; go_mult = 0;
    en_out_h = 0; en_out_l = 0;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp_h,
                             input logic [3:0] exp_l, input logic [2:0] exp_done);
    assertions++;
    if (out_h !== exp_h || out_l !== exp_l ||
        {done_calc, done_div, done_mult} !== exp_done) begin
      failures++;
      $display("[TB] FAIL %s: got h=%h l=%h done=%b%b%b, expected h=%h l=%h done=%b",
               name, out_h, out_l, done_calc, done_div, done_mult, exp_h, exp_l, exp_done);
    end
  endtask

  // Runs one calculator op on the current operands and latches it into out_l.
  task automatic calcAndShow(input logic [1:0] op);
    applyStimulus(0, 0, 0, 0, 1, op, 0, 0, 0, 2'b00, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b01, 0, 1);
  endtask

  initial begin
    en_x = 0; en_y = 0; go_calc = 0; go_div = 0; go_mult = 0;
    sel_h = 0; en_out_h = 0; en_out_l = 0; sel_l = 0; op_calc = 0;
    x = 0; y = 0;
    rst = 1;
    #12;
    checkOutput("reset", 4'h0, 4'h0, 3'b000);
    rst = 0;
    @(posedge clk);
    #1;

    applyStimulus(1, 1, 4'd14, 4'd3, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    calcAndShow(2'b00);
    checkOutput("add", 4'h0, 4'h1, 3'b100);
    calcAndShow(2'b01);
    checkOutput("sub", 4'h0, 4'hB, 3'b100);
    calcAndShow(2'b10);
    checkOutput("and", 4'h0, 4'h2, 3'b100);
    calcAndShow(2'b11);
    checkOutput("xor", 4'h0, 4'hD, 3'b100);

    applyStimulus(0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b11, 1, 1);
    checkOutput("div", 4'h2, 4'h4, 3'b110);

    applyStimulus(0, 1, 0, 4'd0, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b11, 1, 1);
    checkOutput("div_by_zero", 4'hE, 4'hF, 3'b110);

    applyStimulus(0, 1, 0, 4'd3, 0, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 2'b00, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b10, 1, 1);
    checkOutput("mult", 4'h2, 4'hA, 3'b111);

    // Operand load and go on the same edge: the add must still see 14+3.
    applyStimulus(1, 1, 4'd5, 4'd5, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b01, 0, 1);
    checkOutput("load_and_go", 4'h2, 4'h1, 3'b111);
    calcAndShow(2'b00);
    checkOutput("add_new_operands", 4'h2, 4'hA, 3'b111);

    applyStimulus(0, 0, 0, 0, 1, 2'b01, 1, 1, 0, 2'b00, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b11, 1, 1);
    checkOutput("all_units_div", 4'h0, 4'h1, 3'b111);
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b10, 1, 1);
    checkOutput("all_units_mult", 4'h1, 4'h9, 3'b111);
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b01, 0, 1);
    checkOutput("all_units_sub", 4'h1, 4'h0, 3'b111);

    applyStimulus(0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 2'b00, 0, 0);
    rst = 1;
    #1;
    checkOutput("async_reset", 4'h0, 4'h0, 3'b000);
    #2;
    rst = 0;
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b01, 1, 1);
    checkOutput("after_reset", 4'h0, 4'h0, 3'b000);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
